stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 40 ++++
 rtl/stopwatch_core_bcd_to_seg7.sv | 28 ++
 rtl/stopwatch_core.sv | 122 ++++++++++++
 tb/tb_stopwatch_core.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and seven-segment patterns for the stopwatch core.
// Digit pairs are BCD {tens, ones}; segment patterns are active-low {g,f,e,d,c,b,a}.
package stopwatch_pkg;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    // Wrap points expressed in BCD so they compare directly against the digit pairs
    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h99;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max_v);
        bcd2_t r;
        if (v == max_v) begin
            r = 8'h00;
        end else if (v.ones == 4'd9) begin
            r.tens = v.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = v.tens;
            r.ones = v.ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_to_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal codes produce a blank digit.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Pattern lookup for one digit
    always_comb begin
        seg_n = SEG_BLANK;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with pause, per-field adjust and a four-digit multiplexed
// display; all tick inputs are single-cycle enables in the clk domain.
module stopwatch_core
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_cnt,
    input  logic       tick_adj,
    input  logic       tick_disp,
    input  logic       tick_blink,
    input  logic       pause_p,
    input  logic       adj,
    input  logic       sel,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] seg,
    output logic [3:0] an
);

    bcd2_t      min_r;
    bcd2_t      sec_r;
    bcd2_t      min_nxt_s;
    bcd2_t      sec_nxt_s;
    logic       paused_r;
    logic       blink_r;
    logic [1:0] idx_r;
    logic       cnt_en_s;
    logic       adj_min_s;
    logic       adj_sec_s;
    logic       carry_s;
    logic [3:0] digit_s;
    logic [6:0] seg7_s;
    logic [3:0] blank_s;
    logic [7:0] seg_nxt_s;
    logic [3:0] an_nxt_s;
    logic [7:0] seg_r;
    logic [3:0] an_r;

    // Counter next-state; paused_r here is the pre-toggle value
    always_comb begin
        cnt_en_s  = tick_cnt & ~adj & ~paused_r;
        adj_min_s = tick_adj & adj & ~sel;
        adj_sec_s = tick_adj & adj & sel;
        carry_s   = cnt_en_s & (sec_r == SEC_MAX);
        sec_nxt_s = sec_r;
        min_nxt_s = min_r;
        if (cnt_en_s | adj_sec_s) begin
            sec_nxt_s = bcd_inc(sec_r, SEC_MAX);
        end else begin
            sec_nxt_s = sec_r;
        end
        if (carry_s | adj_min_s) begin
            min_nxt_s = bcd_inc(min_r, MIN_MAX);
        end else begin
            min_nxt_s = min_r;
        end
    end

    // Time, pause, scan index and blink state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_r    <= 8'h00;
            sec_r    <= 8'h00;
            paused_r <= 1'b0;
            idx_r    <= 2'd0;
            blink_r  <= 1'b0;
        end else begin
            min_r    <= min_nxt_s;
            sec_r    <= sec_nxt_s;
            paused_r <= paused_r ^ pause_p;
            idx_r    <= idx_r + {1'b0, tick_disp};
            blink_r  <= blink_r ^ tick_blink;
        end
    end

    // Digit select for the current scan position
    always_comb begin
        digit_s = 4'd0;
        case (idx_r)
            2'd0:    digit_s = sec_r.ones;
            2'd1:    digit_s = sec_r.tens;
            2'd2:    digit_s = min_r.ones;
            2'd3:    digit_s = min_r.tens;
            default: digit_s = 4'd0;
        endcase
    end

    bcd_to_seg7 u_seg7 (
        .bcd   (digit_s),
        .seg_n (seg7_s)
    );

    // Digit enables with the field under adjustment blanked on the blink phase
    always_comb begin
        blank_s = 4'b0000;
        if (adj & blink_r) begin
            blank_s = sel ? 4'b0011 : 4'b1100;
        end else begin
            blank_s = 4'b0000;
        end
        an_nxt_s  = ~(4'b0001 << idx_r) | blank_s;
        seg_nxt_s = {(idx_r == 2'd2) ? 1'b0 : 1'b1, seg7_s};
    end

    // Display output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r <= 8'hFF;
            an_r  <= 4'hF;
        end else begin
            seg_r <= seg_nxt_s;
            an_r  <= an_nxt_s;
        end
    end

    assign min_bcd = min_r;
    assign sec_bcd = sec_r;
    assign seg     = seg_r;
    assign an      = an_r;

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios with literal
// expectations, then randomized ticks against a time-in-seconds model.
module tb_stopwatch_core;

    logic       clk;
    logic       rst;
    logic       tick_cnt;
    logic       tick_adj;
    logic       tick_disp;
    logic       tick_blink;
    logic       pause_p;
    logic       adj;
    logic       sel;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] seg;
    logic [3:0] an;

    int         n_checks;
    int         n_errors;

    int         m_min;
    int         m_sec;
    int         m_idx;
    bit         m_paused;
    bit         m_blink;
    logic [7:0] e_seg;
    logic [3:0] e_an;

    stopwatch_core dut (
        .clk        (clk),
        .rst        (rst),
        .tick_cnt   (tick_cnt),
        .tick_adj   (tick_adj),
        .tick_disp  (tick_disp),
        .tick_blink (tick_blink),
        .pause_p    (pause_p),
        .adj        (adj),
        .sel        (sel),
        .min_bcd    (min_bcd),
        .sec_bcd    (sec_bcd),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_min    = 0;
        m_sec    = 0;
        m_idx    = 0;
        m_paused = 0;
        m_blink  = 0;
        e_seg    = 8'hFF;
        e_an     = 4'hF;
    endtask

    // Model of one clock edge, using the inputs as they stand at that edge
    task automatic model_edge();
        int         d;
        int         total;
        logic [3:0] a;
        if (rst) begin
            model_reset();
        end else begin
            case (m_idx)
                0:       d = m_sec % 10;
                1:       d = m_sec / 10;
                2:       d = m_min % 10;
                default: d = m_min / 10;
            endcase
            e_seg = {(m_idx == 2) ? 1'b0 : 1'b1, pat(d)};
            a = 4'b1111;
            a[m_idx] = 1'b0;
            if (adj && m_blink) a = a | (sel ? 4'b0011 : 4'b1100);
            e_an = a;
            if (!adj && !m_paused && tick_cnt) begin
                total = (m_min * 60 + m_sec + 1) % 6000;
                m_min = total / 60;
                m_sec = total % 60;
            end
            if (adj && tick_adj) begin
                if (sel) m_sec = (m_sec + 1) % 60;
                else     m_min = (m_min + 1) % 100;
            end
            if (pause_p)    m_paused = !m_paused;
            if (tick_disp)  m_idx = (m_idx + 1) % 4;
            if (tick_blink) m_blink = !m_blink;
        end
    endtask

    task automatic compare_all();
        chk("min_bcd", min_bcd, to_bcd(m_min));
        chk("sec_bcd", sec_bcd, to_bcd(m_sec));
        chk("seg", seg, e_seg);
        chk("an", {4'h0, an}, {4'h0, e_an});
    endtask

    // One clock: inputs already driven; model follows the edge, compare on negedge
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick(input logic c, input logic a, input logic d,
                        input logic b, input logic p);
        tick_cnt   = c;
        tick_adj   = a;
        tick_disp  = d;
        tick_blink = b;
        pause_p    = p;
        cycle();
    endtask

    // Asynchronous reset mid-cycle, one edge with random ticks held in reset, release
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        tick(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        tick_cnt   = 1'b0;
        tick_adj   = 1'b0;
        tick_disp  = 1'b0;
        tick_blink = 1'b0;
        pause_p    = 1'b0;
        adj        = 1'b0;
        sel        = 1'b0;
        #1;
        model_reset();
        chk("reset_seg", seg, 8'hFF);
        chk("reset_an", {4'h0, an}, 8'h0F);
        chk("reset_time", {min_bcd | sec_bcd}, 8'h00);
        @(negedge clk);
        do_reset();

        // 61 counting ticks from reset
        for (int i = 0; i < 61; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t61_min", min_bcd, 8'h01);
        chk("t61_sec", sec_bcd, 8'h01);

        // Preload 99:59 via adjust, then one count tick wraps to 00:00
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 99; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sel = 1'b1;
        for (int i = 0; i < 59; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre_min", min_bcd, 8'h99);
        chk("pre_sec", sec_bcd, 8'h59);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("adj_cnt_ignored", sec_bcd, 8'h59);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("adj_sec_wrap", sec_bcd, 8'h00);
        chk("adj_sec_nocarry", min_bcd, 8'h99);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 58; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        adj = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mode_change_hold", sec_bcd, 8'h59);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_min", min_bcd, 8'h00);
        chk("wrap_sec", sec_bcd, 8'h00);

        // Pause coinciding with a count tick at 00:05
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pause_same_cycle", sec_bcd, 8'h06);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("paused_hold", sec_bcd, 8'h06);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("resumed", sec_bcd, 8'h07);

        // Display scan of 12:34 with blink phase 0
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        sel = 1'b1;
        for (int i = 0; i < 34; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("scan0_an", {4'h0, an}, 8'h0E);
        chk("scan0_seg", seg, 8'h99);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("scan1_an", {4'h0, an}, 8'h0D);
        chk("scan1_seg", seg, 8'hB0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("scan2_an", {4'h0, an}, 8'h0B);
        chk("scan2_seg", seg, 8'h24);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("scan3_an", {4'h0, an}, 8'h07);
        chk("scan3_seg", seg, 8'hF9);

        // Blink blanking of the minutes field, then adj=0 removes it
        sel = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("blink_min_an3", {4'h0, an}, 8'h0F);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("blink_sec_an0", {4'h0, an}, 8'h0E);
        adj = 1'b0;
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("noblink_an2", {4'h0, an}, 8'h0B);

        // Randomized operation
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) adj = 1'($urandom);
            if ($urandom_range(0, 39) == 0) sel = 1'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick(1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 15) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
